// File: rtl/param_registry_pkg.sv
// param_registry_pkg
// Shared types and derived-width helpers for the CAN acceptance parameter
// registry: the loader state enum, payload/byte/index width functions and
// the bit positions inside the frame header byte.
package param_registry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    // Header byte layout: bit7 enables the bank, bits[6:0] select it.
    localparam int HDR_EN_BIT  = 7;
    localparam int HDR_IDX_MSB = 6;

    // Payload is {sjw, code, mask}, mask in the lowest bits.
    function automatic int calc_pay_w(input int id_w, input int sjw_w);
        return 2 * id_w + sjw_w;
    endfunction

    function automatic int calc_nbytes(input int pay_w);
        return (pay_w + 7) / 8;
    endfunction

    function automatic int calc_idx_w(input int num_filters);
        return (num_filters <= 1) ? 1 : $clog2(num_filters);
    endfunction

endpackage

// File: rtl/param_registry_if.sv
// param_registry_if
// Groups the byte-serial configuration stream (param_id/data_valid/data with
// busy/load_done/load_err status) and the RX identifier match path
// (rx_id/rx_id_valid in, match_valid/match_hit/match_idx out).
//   master : host / RX filter side, drives the stream and identifiers
//   slave  : the registry itself
interface param_registry_if
    import param_registry_pkg::*;
#(
    parameter int NUM_FILTERS = 4,
    parameter int ID_W        = 11
);
    localparam int IDX_W = calc_idx_w(NUM_FILTERS);

    logic             param_id;
    logic             data_valid;
    logic [7:0]       data;
    logic             busy;
    logic             load_done;
    logic             load_err;
    logic [ID_W-1:0]  rx_id;
    logic             rx_id_valid;
    logic             match_valid;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;

    modport master (
        output param_id, data_valid, data, rx_id, rx_id_valid,
        input  busy, load_done, load_err, match_valid, match_hit, match_idx
    );

    modport slave (
        input  param_id, data_valid, data, rx_id, rx_id_valid,
        output busy, load_done, load_err, match_valid, match_hit, match_idx
    );

endinterface

// File: rtl/param_match.sv
// param_match
// Compares one identifier against every filter bank and reports the lowest
// enabled bank whose masked code equals the masked identifier. Results are
// registered: a strobe at cycle t appears as match_valid at t+1, and
// match_hit/match_idx hold their value between strobes.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   rx_id, rx_id_valid  identifier to classify and its qualifier
//   mask, code, en      bank contents (mask bit 1 = compare this bit)
//   match_valid         one cycle after rx_id_valid
//   match_hit           any enabled bank matched
//   match_idx           lowest matching bank, 0 when no hit
module param_match
    import param_registry_pkg::*;
#(
    parameter int NUM_FILTERS = 4,
    parameter int ID_W        = 11,
    parameter int IDX_W       = calc_idx_w(NUM_FILTERS)
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [ID_W-1:0]                      rx_id,
    input  logic                                 rx_id_valid,
    input  logic [NUM_FILTERS-1:0][ID_W-1:0]     mask,
    input  logic [NUM_FILTERS-1:0][ID_W-1:0]     code,
    input  logic [NUM_FILTERS-1:0]               en,
    output logic                                 match_valid,
    output logic                                 match_hit,
    output logic [IDX_W-1:0]                     match_idx
);

    logic [NUM_FILTERS-1:0] hit;
    logic                   any_hit;
    logic [IDX_W-1:0]       first_idx;

    for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_bank
        assign hit[i] = en[i] && (((rx_id ^ code[i]) & mask[i]) == '0);
    end

    // Scanning downwards lets the lowest hitting bank overwrite the others.
    always_comb begin
        any_hit   = 1'b0;
        first_idx = '0;
        for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit   = 1'b1;
                first_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_valid <= 1'b0;
            match_hit   <= 1'b0;
            match_idx   <= '0;
        end else begin
            match_valid <= rx_id_valid;
            if (rx_id_valid) begin
                match_hit <= any_hit;
                match_idx <= first_idx;
            end
        end
    end

endmodule

// File: rtl/param_registry.sv
// param_registry
// Loads CAN acceptance parameters (mask, code, SJW, enable) into one of
// NUM_FILTERS banks from a byte-serial stream, and classifies incoming RX
// identifiers against the enabled banks.
// A frame is: param_id strobe, header byte {en, idx[6:0]}, then NBYTES
// payload bytes packed LSB-first as {sjw, code, mask}. Payload bytes collect
// in a shadow register and reach the bank only in the single COMMIT cycle,
// so an aborted or reset frame never disturbs the visible bank contents.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   bus (slave)        config stream, status and match path
//   mask_param         bank masks, bank i at [i*ID_W +: ID_W]
//   code_param         bank codes, same layout
//   sjw                bank SJW, bank i at [i*SJW_W +: SJW_W]
//   filter_en          bank enables
module param_registry
    import param_registry_pkg::*;
#(
    parameter int NUM_FILTERS = 4,
    parameter int ID_W        = 11,
    parameter int SJW_W       = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    param_registry_if.slave               bus,
    output logic [NUM_FILTERS*ID_W-1:0]   mask_param,
    output logic [NUM_FILTERS*ID_W-1:0]   code_param,
    output logic [NUM_FILTERS*SJW_W-1:0]  sjw,
    output logic [NUM_FILTERS-1:0]        filter_en
);

    localparam int PAY_W  = calc_pay_w(ID_W, SJW_W);
    localparam int NBYTES = calc_nbytes(PAY_W);
    localparam int IDX_W  = calc_idx_w(NUM_FILTERS);
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t                            state, state_nxt;
    logic [CNT_W-1:0]                  cnt;
    logic [TO_W-1:0]                   idle_cnt;
    logic [NBYTES-1:0][7:0]            shadow;
    logic [NBYTES*8-1:0]               shadow_flat;
    logic [IDX_W-1:0]                  idx_q;
    logic                              en_q;

    logic [NUM_FILTERS-1:0][ID_W-1:0]  mask_q, code_q;
    logic [NUM_FILTERS-1:0][SJW_W-1:0] sjw_q;
    logic [NUM_FILTERS-1:0]            en_bank;

    logic framed, byte_in, bad_idx, last_byte, timeout, idle_tick;

    assign framed      = (state == HDR) || (state == PAYLOAD);
    // param_id outranks a byte presented in the same cycle.
    assign byte_in     = bus.data_valid && !bus.param_id;
    assign bad_idx     = {25'd0, bus.data[HDR_IDX_MSB:0]} >= 32'(NUM_FILTERS);
    assign last_byte   = (cnt == CNT_W'(NBYTES - 1));
    // Fires on the TIMEOUT-th consecutive byte-less cycle inside a frame.
    assign timeout     = (TIMEOUT != 0) && framed && !bus.param_id && !bus.data_valid
                         && ((32'(idle_cnt) + 32'd1) == 32'(TIMEOUT));
    assign idle_tick   = framed && !bus.param_id && !bus.data_valid && !timeout;
    assign shadow_flat = shadow;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.param_id) state_nxt = HDR;
            HDR: begin
                if (bus.param_id)     state_nxt = HDR;
                else if (byte_in)     state_nxt = bad_idx ? IDLE : PAYLOAD;
                else if (timeout)     state_nxt = IDLE;
            end
            PAYLOAD: begin
                if (bus.param_id)             state_nxt = HDR;
                else if (byte_in && last_byte) state_nxt = COMMIT;
                else if (timeout)             state_nxt = IDLE;
            end
            COMMIT:  state_nxt = bus.param_id ? HDR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.load_done = (state == COMMIT);
        bus.load_err  = 1'b0;
        if (framed && (bus.param_id || timeout)) bus.load_err = 1'b1;
        if (state == HDR && byte_in && bad_idx)  bus.load_err = 1'b1;
    end

    // ---------------- Shadow, counters, header latch ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow   <= '0;
            cnt      <= '0;
            idle_cnt <= '0;
            idx_q    <= '0;
            en_q     <= 1'b0;
        end else begin
            idle_cnt <= idle_tick ? idle_cnt + TO_W'(1) : '0;
            if (bus.param_id) begin
                // Every state restarts a frame on param_id; drop old shadow.
                shadow <= '0;
                cnt    <= '0;
            end else if (state == HDR && byte_in) begin
                idx_q <= bus.data[IDX_W-1:0];
                en_q  <= bus.data[HDR_EN_BIT];
                cnt   <= '0;
            end else if (state == PAYLOAD && byte_in) begin
                shadow[cnt] <= bus.data;
                if (cnt != CNT_W'(NBYTES)) cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // ---------------- Bank storage, written only in COMMIT ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q  <= '0;
            code_q  <= '0;
            sjw_q   <= '0;
            en_bank <= '0;
        end else if (state == COMMIT) begin
            mask_q[idx_q]  <= shadow_flat[ID_W-1:0];
            code_q[idx_q]  <= shadow_flat[2*ID_W-1:ID_W];
            sjw_q[idx_q]   <= shadow_flat[PAY_W-1:2*ID_W];
            en_bank[idx_q] <= en_q;
        end
    end

    // Padding bits above PAY_W in the last payload byte carry no meaning.
    if (NBYTES * 8 > PAY_W) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^shadow_flat[NBYTES*8-1:PAY_W];
    end

    assign mask_param = mask_q;
    assign code_param = code_q;
    assign sjw        = sjw_q;
    assign filter_en  = en_bank;

    param_match #(
        .NUM_FILTERS (NUM_FILTERS),
        .ID_W        (ID_W),
        .IDX_W       (IDX_W)
    ) u_match (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_id       (bus.rx_id),
        .rx_id_valid (bus.rx_id_valid),
        .mask        (mask_q),
        .code        (code_q),
        .en          (en_bank),
        .match_valid (bus.match_valid),
        .match_hit   (bus.match_hit),
        .match_idx   (bus.match_idx)
    );

endmodule
